// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer, its instruction memory and decode.
// The master side is the sequencer. state_dbg mirrors its FSM state.
interface imem_fetch_ctrl_if;
    logic        en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;
    logic        state_dbg;

    // Handshake: an instruction moves to decode on a cycle where out_valid
    // and out_ready are both high. out_valid never depends on out_ready
    // combinationally. While out_valid=1 and out_ready=0, out_pc and
    // out_instr hold steady.
    modport master (
        input  en, imem_rdata, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_pc, out_instr, fault, fault_pc,
        output fetch_count, state_dbg
    );

    modport slave (
        output en, imem_rdata, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_pc, out_instr, fault, fault_pc,
        input  fetch_count, state_dbg
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer. It owns the PC and registers each fetched word
// in a one-entry output stage. It also handles redirects, fault states and a
// count of accepted instructions.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS  = 20,
    parameter logic [31:0] FAULT_INSTR = 32'hDEAD_BEEF
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_fetch_ctrl_if.master  bus
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    localparam logic [29:0] WORD_LIMIT = 30'(IMEM_WORDS);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic handshake;
    logic slot_free;
    logic redirect_bad;
    logic pc_oob;

    assign handshake    = out_valid_q && bus.out_ready;
    assign slot_free    = !out_valid_q || bus.out_ready;
    assign redirect_bad = (bus.redirect_pc[1:0] != 2'b00) ||
                          (bus.redirect_pc[31:2] >= WORD_LIMIT);
    assign pc_oob       = pc_q[31:2] >= WORD_LIMIT;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_instr_d   = out_instr_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        fetch_count_d = fetch_count_q;

        // A handshake on a redirect cycle still counts before the flush.
        if (handshake && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        case (state_q)
            ST_FETCH: begin
                if (bus.redirect_valid) begin
                    out_valid_d = 1'b0;
                    if (redirect_bad) begin
                        state_d     = ST_FAULT;
                        fault_d     = 1'b1;
                        fault_pc_d  = bus.redirect_pc;
                        out_instr_d = FAULT_INSTR;
                    end else begin
                        pc_d = bus.redirect_pc;
                    end
                end else if (bus.en && slot_free) begin
                    if (pc_oob) begin
                        state_d     = ST_FAULT;
                        fault_d     = 1'b1;
                        fault_pc_d  = pc_q;
                        out_valid_d = 1'b0;
                        out_instr_d = FAULT_INSTR;
                    end else begin
                        out_instr_d = bus.imem_rdata;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + 32'd4;
                    end
                end else if (handshake) begin
                    out_valid_d = 1'b0;
                end
            end
            ST_FAULT: begin
                // Only a redirect to a legal target can leave this state.
                if (bus.redirect_valid) begin
                    if (redirect_bad) begin
                        fault_pc_d = bus.redirect_pc;
                    end else begin
                        state_d = ST_FETCH;
                        fault_d = 1'b0;
                        pc_d    = bus.redirect_pc;
                    end
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_pc_q      <= 32'h0;
            out_instr_q   <= 32'h0;
            fault_q       <= 1'b0;
            fault_pc_q    <= 32'h0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_instr_q   <= out_instr_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.fault       = fault_q;
    assign bus.fault_pc    = fault_pc_q;
    assign bus.fetch_count = fetch_count_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl. A scoreboard queue holds the expected
// {pc, instr} pairs, and a negedge monitor checks each accepted instruction.
module tb_imem_fetch_ctrl;
    localparam int W = 64;

    logic clk;
    logic rst_n;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_WORDS  (20),
        .FAULT_INSTR (32'hDEAD_BEEF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Memory model: word i holds 0x100 + i.
    assign bus.imem_rdata = 32'h100 + (bus.imem_addr >> 2);

    logic [W-1:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, 32'h100 + (pc >> 2)});
    endtask

    task automatic push_range(input logic [31:0] first, input logic [31:0] last);
        for (logic [31:0] p = first; p <= last; p += 4) push_exp(p);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_out: got pc %h instr %h expected none",
                         bus.out_pc, bus.out_instr);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("out_pc", bus.out_pc, e[63:32]);
                check("out_instr", bus.out_instr, e[31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n              = 1'b0;
        bus.en             = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        step();
        step();
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_fault", {31'h0, bus.fault}, 32'h0);
        check("rst_fault_pc", bus.fault_pc, 32'h0);
        check("rst_fetch_count", bus.fetch_count, 32'h0);
        check("rst_imem_addr", bus.imem_addr, 32'h0);

        // Test 1: stream from reset, five handshakes.
        rst_n = 1'b1;
        bus.en = 1'b1;
        bus.out_ready = 1'b1;
        push_range(32'h0, 32'h10);
        check("t1_valid_before", {31'h0, bus.out_valid}, 32'h0);
        step();
        check("t1_valid_after", {31'h0, bus.out_valid}, 32'h1);
        check("t1_first_pc", bus.out_pc, 32'h0);
        repeat (4) step();
        bus.en = 1'b0;
        step();
        check("t1_fetch_count", bus.fetch_count, 32'd5);
        check("t1_drained", {31'h0, bus.out_valid}, 32'h0);

        // Test 2: restart, then backpressure while pc 8 is held.
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        step();
        rst_n = 1'b1;
        bus.en = 1'b1;
        bus.out_ready = 1'b1;
        push_range(32'h0, 32'hC);
        repeat (3) step();
        check("t2_held_pc0", bus.out_pc, 32'h8);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_hold_valid", {31'h0, bus.out_valid}, 32'h1);
            check("t2_hold_pc", bus.out_pc, 32'h8);
            check("t2_hold_instr", bus.out_instr, 32'h102);
            check("t2_hold_addr", bus.imem_addr, 32'hC);
        end
        bus.out_ready = 1'b1;
        step();
        check("t2_resume_pc", bus.out_pc, 32'hC);

        // Test 3: redirect to 0x20 while pc 0xC is presented and accepted.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h20;
        push_range(32'h20, 32'h4C);
        step();
        bus.redirect_valid = 1'b0;
        check("t3_flush_valid", {31'h0, bus.out_valid}, 32'h0);
        check("t3_redirect_addr", bus.imem_addr, 32'h20);
        step();
        check("t3_target_pc", bus.out_pc, 32'h20);
        check("t3_target_instr", bus.out_instr, 32'h108);

        // Test 4: run off the end of memory at 0x50.
        for (int i = 0; i < 40 && !bus.fault; i++) step();
        check("t4_fault", {31'h0, bus.fault}, 32'h1);
        check("t4_fault_pc", bus.fault_pc, 32'h50);
        check("t4_valid", {31'h0, bus.out_valid}, 32'h0);
        check("t4_fault_instr", bus.out_instr, 32'hDEAD_BEEF);
        check("t4_fetch_count", bus.fetch_count, 32'd16);
        check("t4_frozen_addr", bus.imem_addr, 32'h50);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        step();
        bus.redirect_valid = 1'b0;
        check("t4_exit_fault", {31'h0, bus.fault}, 32'h0);
        check("t4_keep_fault_pc", bus.fault_pc, 32'h50);
        check("t4_exit_valid", {31'h0, bus.out_valid}, 32'h0);
        push_exp(32'h0);
        step();
        check("t4_resume_pc", bus.out_pc, 32'h0);

        // Test 5: misaligned redirect, then en toggling in FAULT.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h6;
        step();
        bus.redirect_valid = 1'b0;
        check("t5_fault", {31'h0, bus.fault}, 32'h1);
        check("t5_fault_pc", bus.fault_pc, 32'h6);
        check("t5_fault_instr", bus.out_instr, 32'hDEAD_BEEF);
        check("t5_fetch_count", bus.fetch_count, 32'd17);
        check("t5_frozen_addr", bus.imem_addr, 32'h4);
        for (int i = 0; i < 6; i++) begin
            bus.en = i[0];
            step();
            check("t5_no_output", {31'h0, bus.out_valid}, 32'h0);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h50;
        step();
        check("t5_bad_update_pc", bus.fault_pc, 32'h50);
        check("t5_still_fault", {31'h0, bus.fault}, 32'h1);
        bus.redirect_pc    = 32'h10;
        bus.en             = 1'b1;
        bus.out_ready      = 1'b0;
        step();
        bus.redirect_valid = 1'b0;
        check("t5_exit_fault", {31'h0, bus.fault}, 32'h0);
        step();
        check("t5_fetch_valid", {31'h0, bus.out_valid}, 32'h1);
        check("t5_fetch_pc", bus.out_pc, 32'h10);
        check("t5_fetch_instr", bus.out_instr, 32'h104);

        // Test 6: asynchronous reset with an instruction held.
        rst_n = 1'b0;
        #1;
        check("t6_valid", {31'h0, bus.out_valid}, 32'h0);
        check("t6_out_pc", bus.out_pc, 32'h0);
        check("t6_out_instr", bus.out_instr, 32'h0);
        check("t6_fault_pc", bus.fault_pc, 32'h0);
        check("t6_fetch_count", bus.fetch_count, 32'h0);
        check("t6_imem_addr", bus.imem_addr, 32'h0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        push_exp(32'h0);
        push_exp(32'h4);
        step();
        check("t6_restart_pc0", bus.out_pc, 32'h0);
        step();
        check("t6_restart_pc1", bus.out_pc, 32'h4);
        bus.en = 1'b0;
        step();
        step();
        check("t6_fetch_count", bus.fetch_count, 32'd2);
        check("sb_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer for the word-addressed, combinational-read instruction memory. It owns the PC and drives the byte address to the memory. It registers each returned word together with its PC into a one-entry output stage, using a valid/ready handshake toward decode. It also handles redirects from branch/jump resolution, bounds and alignment faults, and an accepted-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
IMEM_WORDS, 20, number of valid instruction words; word index pc[31:2] must be < IMEM_WORDS.
FAULT_INSTR, 32'hDEAD_BEEF, value driven on out_instr while in FAULT.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  run enable; when low, no new fetch is issued.
imem_addr  output  32  byte address to instruction memory, always equal to the internal pc.
imem_rdata  input  32  combinational read data for imem_addr.
redirect_valid  input  1  one-cycle pulse requesting a PC change.
redirect_pc  input  32  target byte address, sampled when redirect_valid=1.
out_valid  output  1  out_pc/out_instr hold a fetched instruction.
out_ready  input  1  decode accepts the instruction this cycle.
out_pc  output  32  PC of the held instruction.
out_instr  output  32  held instruction word.
fault  output  1  high while in FAULT state.
fault_pc  output  32  offending address captured on fault entry.
fetch_count  output  32  number of handshakes completed (out_valid && out_ready).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=FETCH.
  - out_valid=0, out_pc=0, out_instr=0.
  - fault=0, fault_pc=0, fetch_count=0.
  - Reset asserted mid-operation discards any held instruction immediately.
- States:
  - FETCH: normal operation.
  - FAULT: fetch stopped.
- Slot free = (!out_valid) || out_ready.
- FETCH, per cycle, in priority order:
  1. redirect_valid=1:
     - Flush: out_valid<=0 next cycle. A handshake in the same cycle still counts in fetch_count.
     - If redirect_pc[1:0]!=0 or redirect_pc[31:2]>=IMEM_WORDS: state<=FAULT, fault_pc<=redirect_pc.
     - Otherwise pc<=redirect_pc.
     - No fetch is issued this cycle.
  2. en=1 and slot free:
     - If pc[31:2]>=IMEM_WORDS: state<=FAULT, fault_pc<=pc, out_valid<=0.
     - Otherwise: out_instr<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+4 (32-bit wrap; an overflow then faults on the bounds check).
  3. Otherwise (en=0 or stalled):
     - pc is unchanged.
     - On out_ready with out_valid=1: out_valid<=0.
     - While out_valid=1 and out_ready=0, out_valid/out_pc/out_instr are held stable.
- Latency and throughput:
  - Instruction for PC p appears on out_* the cycle after p is on imem_addr.
  - With out_ready held high and no redirect: one instruction per cycle, back-to-back.
- en deassertion: a pending out_valid stays until accepted; no new fetch is issued.
- FAULT:
  - fault=1, out_valid=0, out_instr=FAULT_INSTR; pc is frozen.
  - en and out_ready are ignored.
  - Exit only via a redirect_valid with an aligned, in-bounds target: state<=FETCH, fault<=0, pc<=redirect_pc; fault_pc is retained.
  - A bad redirect while in FAULT updates fault_pc.
  - Reset also clears FAULT.
- fetch_count: increments on every out_valid && out_ready, saturating at 32'hFFFF_FFFF.
- imem_addr never changes except at a clock edge or reset.

Test Plan:
1. Reset release with RESET_PC=0, en=1, out_ready=1, memory word i = 32'h100+i -> out_valid rises 1 cycle later; out_pc = 0, 4, 8…; out_instr = 0x100, 0x101…; fetch_count = 5 after 5 handshakes.
2. Backpressure: out_ready=0 for 3 cycles while out_pc=8 is held -> out_pc/out_instr stay 8/0x102, imem_addr stays 12; on out_ready=1, next out_pc=12 with no skip or duplicate.
3. Redirect to 0x20 while out_valid=1 -> out_valid=0 next cycle; following output out_pc=0x20, out_instr=0x108.
4. Sequential fetch to pc=0x50 (index 20 = IMEM_WORDS) -> fault=1, fault_pc=0x50, out_valid=0, out_instr=0xDEADBEEF; redirect to 0x0 -> fault=0, fetch resumes at 0.
5. Redirect to 0x06 (misaligned) -> FAULT with fault_pc=0x06; en toggling produces no output.
6. rst_n pulsed low mid-stream with out_valid=1 -> all outputs are reset values immediately; fetch restarts from RESET_PC after release.
